// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter that lets NB_REQ requesters share one APB master port.
// It runs the full SETUP/ACCESS sequence, returns each response to the
// requester that was granted, and aborts an ACCESS phase through a PREADY
// watchdog so that a hung peripheral cannot hold the bus.
module apb_rr_master_arb #(
    parameter int NB_REQ         = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_REQ-1:0]                  req_i,
    input  logic [NB_REQ-1:0]                  we_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
    output logic [NB_REQ-1:0]                  gnt_o,
    output logic [NB_REQ-1:0]                  rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]          rdata_o,
    output logic                               err_o,
    output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
    output logic                               pwrite_o,
    output logic                               psel_o,
    output logic                               penable_o,
    input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
    input  logic                               pready_i,
    input  logic                               pslverr_i
);

    localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [PTR_W-1:0]  ptr_reg;       // last granted requester
    logic [PTR_W-1:0]  winner;
    logic              found;
    logic [WD_W-1:0]   wd_reg;        // ACCESS cycles spent so far (1-based)
    logic              done;
    logic              timeout;

    logic [APB_ADDR_WIDTH-1:0] addr_arr  [NB_REQ];
    logic [APB_DATA_WIDTH-1:0] wdata_arr [NB_REQ];

    // Unpack the flat requester buses into per-requester slices
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr_i[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        assign wdata_arr[gi] = wdata_i[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end

    // Round-robin pick: first active request scanning upward from ptr+1
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NB_REQ; i++) begin
            idx = (int'(ptr_reg) + i) % NB_REQ;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    // A completing PREADY always wins over a watchdog abort in the same cycle
    assign done    = (state_reg == ST_ACCESS) && pready_i;
    assign timeout = (state_reg == ST_ACCESS) && !pready_i && (TIMEOUT_CYCLES != 0)
                     && (wd_reg == WD_W'(TIMEOUT_CYCLES));

    assign psel_o    = (state_reg != ST_IDLE);
    assign penable_o = (state_reg == ST_ACCESS);

    // Next-state and combinational grant
    always_comb begin
        state_next = state_reg;
        gnt_o      = '0;
        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    gnt_o[winner] = 1'b1;
                    state_next    = ST_SETUP;
                end
            end
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (done || timeout) begin
                    state_next = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // State, pointer and capture of the winning requester's transfer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= PTR_W'(NB_REQ - 1);
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pwrite_o  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && found) begin
                ptr_reg  <= winner;
                paddr_o  <= addr_arr[winner];
                pwdata_o <= wdata_arr[winner];
                pwrite_o <= we_i[winner];
            end
        end
    end

    // Response strobe routed to the requester that owns the current transfer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= '0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= '0;
            err_o    <= 1'b0;
            if (done) begin
                rvalid_o <= NB_REQ'(1) << ptr_reg;
                rdata_o  <= pwrite_o ? '0 : prdata_i;
                err_o    <= pslverr_i;
            end else if (timeout) begin
                rvalid_o <= NB_REQ'(1) << ptr_reg;
                rdata_o  <= '0;
                err_o    <= 1'b1;
            end
        end
    end

    // PREADY watchdog: 1 in the first ACCESS cycle, cleared outside ACCESS
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_reg <= '0;
        end else if (state_reg == ST_SETUP) begin
            wd_reg <= WD_W'(1);
        end else if (state_reg == ST_ACCESS && !done && !timeout) begin
            if (wd_reg != '1) begin
                wd_reg <= wd_reg + WD_W'(1);
            end
        end else begin
            wd_reg <= '0;
        end
    end

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Directed bench for apb_rr_master_arb: a table of single transfers plus
// hand-written sequences for back-to-back grants and reset during ACCESS.
module tb_apb_rr_master_arb;

    localparam logic [31:0] ADDR0 = 32'h1A10_0000;
    localparam logic [31:0] ADDR1 = 32'h1A10_1000;
    localparam logic [31:0] WD0   = 32'h0000_CAFE;
    localparam logic [31:0] WD1   = 32'h0000_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_rdata;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        int          waits;     // PREADY-low ACCESS cycles; >=4 means never ready
        logic        slverr;
        logic [31:0] prdata;
        int          exp_win;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    apb_rr_master_arb #(
        .NB_REQ(2), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .pwrite_o(pwrite_o), .psel_o(psel_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v, input int num);
        logic [1:0]  exp_gnt;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic        exp_we;
        exp_gnt  = 2'b01 << v.exp_win;
        exp_addr = (v.exp_win == 1) ? ADDR1 : ADDR0;
        exp_wd   = (v.exp_win == 1) ? WD1 : WD0;
        exp_we   = v.we[v.exp_win];
        // idle cycle: previous response data must still be held
        check("rdata_hold", 64'(rdata_o), 64'(last_rdata));
        check("idle_rvalid", 64'(rvalid_o), 64'(0));
        req_i = v.req;
        we_i  = v.we;
        #1;
        check("gnt", 64'(gnt_o), 64'(exp_gnt));
        // SETUP
        @(negedge clk_i);
        req_i = 2'b00;
        #1;
        check("setup_psel_pen", 64'({psel_o, penable_o}), 64'(2'b10));
        check("setup_paddr", 64'(paddr_o), 64'(exp_addr));
        check("setup_pwdata", 64'(pwdata_o), 64'(exp_wd));
        check("setup_pwrite", 64'(pwrite_o), 64'(exp_we));
        // ACCESS, at most four cycles before the watchdog fires
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            pready_i  = (k == v.waits);
            pslverr_i = v.slverr;
            prdata_i  = v.prdata;
            #1;
            check("access_psel_pen", 64'({psel_o, penable_o}), 64'(2'b11));
            check("access_paddr", 64'(paddr_o), 64'(exp_addr));
            check("access_rvalid", 64'(rvalid_o), 64'(0));
            if (k == v.waits) break;
        end
        // response
        @(negedge clk_i);
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        #1;
        check("rvalid", 64'(rvalid_o), 64'(exp_gnt));
        check("err", 64'(err_o), 64'(v.exp_err));
        check("rdata", 64'(rdata_o), 64'(v.exp_rdata));
        check("resp_psel_pen", 64'({psel_o, penable_o}), 64'(2'b00));
        last_rdata = v.exp_rdata;
        $display("xfer %0d: req=%b win=%0d rvalid=%b err=%b rdata=%08h",
                 num, v.req, v.exp_win, rvalid_o, err_o, rdata_o);
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        // ptr starts at 1 after reset, so requester 0 is first in line
        vecs[0] = '{2'b01, 2'b01, 0, 1'b0, 32'h0,         0, 1'b0, 32'h0};
        vecs[1] = '{2'b11, 2'b00, 0, 1'b0, 32'h1111_0001, 1, 1'b0, 32'h1111_0001};
        vecs[2] = '{2'b11, 2'b00, 0, 1'b0, 32'h2222_0002, 0, 1'b0, 32'h2222_0002};
        vecs[3] = '{2'b11, 2'b11, 0, 1'b0, 32'h3333_0003, 1, 1'b0, 32'h0};
        vecs[4] = '{2'b11, 2'b11, 0, 1'b0, 32'h4444_0004, 0, 1'b0, 32'h0};
        vecs[5] = '{2'b10, 2'b00, 3, 1'b0, 32'h1234_5678, 1, 1'b0, 32'h1234_5678};
        vecs[6] = '{2'b01, 2'b00, 0, 1'b1, 32'hDEAD_0000, 0, 1'b1, 32'hDEAD_0000};
        vecs[7] = '{2'b01, 2'b00, 0, 1'b0, 32'h0000_55AA, 0, 1'b0, 32'h0000_55AA};
        vecs[8] = '{2'b10, 2'b00, 9, 1'b0, 32'hFFFF_FFFF, 1, 1'b1, 32'h0};
        vecs[9] = '{2'b01, 2'b01, 3, 1'b0, 32'h7777_0007, 0, 1'b0, 32'h0};

        rst_i      = 1'b1;
        req_i      = 2'b00;
        we_i       = 2'b00;
        addr_i     = {ADDR1, ADDR0};
        wdata_i    = {WD1, WD0};
        prdata_i   = 32'h0;
        pready_i   = 1'b0;
        pslverr_i  = 1'b0;
        last_rdata = 32'h0;

        // reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_gnt", 64'(gnt_o), 64'(0));
        check("rst_rvalid", 64'(rvalid_o), 64'(0));
        check("rst_rdata", 64'(rdata_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_paddr", 64'(paddr_o), 64'(0));
        check("rst_pwdata", 64'(pwdata_o), 64'(0));
        check("rst_pwrite", 64'(pwrite_o), 64'(0));
        check("rst_psel_pen", 64'({psel_o, penable_o}), 64'(0));
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 10; i++) begin
            run_xfer(vecs[i], i);
        end

        // back-to-back with req held: rvalid and next grant share a cycle (ptr=0)
        we_i     = 2'b00;
        pready_i = 1'b1;
        prdata_i = 32'hA5A5_0001;
        req_i    = 2'b11;
        #1;
        check("b2b_gnt_c0", 64'(gnt_o), 64'(2'b10));
        @(negedge clk_i); #1;
        check("b2b_setup_paddr", 64'(paddr_o), 64'(ADDR1));
        @(negedge clk_i); #1;
        check("b2b_access_pen", 64'(penable_o), 64'(1));
        @(negedge clk_i); #1;
        check("b2b_rvalid_c3", 64'(rvalid_o), 64'(2'b10));
        check("b2b_rdata_c3", 64'(rdata_o), 64'(32'hA5A5_0001));
        check("b2b_gnt_c3", 64'(gnt_o), 64'(2'b01));
        $display("b2b xfer A: rvalid=%b rdata=%08h next gnt=%b", rvalid_o, rdata_o, gnt_o);
        @(negedge clk_i);
        prdata_i = 32'hA5A5_0002;
        #1;
        check("b2b_setup_paddr2", 64'(paddr_o), 64'(ADDR0));
        @(negedge clk_i); #1;
        check("b2b_access_pen2", 64'(penable_o), 64'(1));
        @(negedge clk_i); #1;
        check("b2b_rvalid_c6", 64'(rvalid_o), 64'(2'b01));
        check("b2b_rdata_c6", 64'(rdata_o), 64'(32'hA5A5_0002));
        check("b2b_gnt_c6", 64'(gnt_o), 64'(2'b10));
        $display("b2b xfer B: rvalid=%b rdata=%08h next gnt=%b", rvalid_o, rdata_o, gnt_o);

        // reset during ACCESS drops the transfer
        @(negedge clk_i);
        req_i    = 2'b00;
        pready_i = 1'b0;
        #1;
        check("rstx_setup_psel", 64'(psel_o), 64'(1));
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rstx_access_pen", 64'(penable_o), 64'(1));
        @(negedge clk_i); #1;
        check("rstx_psel_pen", 64'({psel_o, penable_o}), 64'(0));
        check("rstx_rvalid", 64'(rvalid_o), 64'(0));
        rst_i = 1'b0;
        @(negedge clk_i); #1;
        check("rstx_rvalid_after", 64'(rvalid_o), 64'(0));
        check("rstx_rdata", 64'(rdata_o), 64'(0));
        req_i = 2'b11;
        #1;
        check("rstx_gnt_req0", 64'(gnt_o), 64'(2'b01));
        $display("reset in ACCESS: psel=%b rvalid=%b first gnt=%b", psel_o, rvalid_o, gnt_o);
        @(negedge clk_i);
        req_i = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
